// File: rtl/bexkat2_intseq.sv
// bexkat2_intseq: multi-cycle integer sequencer for the bexkat2 CPU.
// Multiply uses a radix-2 shift-add over operand magnitudes. Divide uses a
// restoring divider and is built only when BEXKAT2_INTDIV_EN is defined.
// Without that macro the divide codes behave like unused codes.
module bexkat2_intseq (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [3:0]  func_i,
    input  logic [31:0] in1_i,
    input  logic [31:0] in2_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] out_o,
    output logic        div0_o
);
    localparam logic [3:0] F_MUL   = 4'd0;
    localparam logic [3:0] F_DIV   = 4'd1;
    localparam logic [3:0] F_MOD   = 4'd2;
    localparam logic [3:0] F_MULU  = 4'd3;
    localparam logic [3:0] F_DIVU  = 4'd4;
    localparam logic [3:0] F_MODU  = 4'd5;
    localparam logic [3:0] F_MULX  = 4'd6;
    localparam logic [3:0] F_MULUX = 4'd7;
    localparam logic [3:0] F_EXT   = 4'd8;
    localparam logic [3:0] F_EXTB  = 4'd9;
    localparam logic [3:0] F_COM   = 4'd10;
    localparam logic [3:0] F_NEG   = 4'd11;

`ifdef BEXKAT2_INTDIV_EN
    typedef enum logic [2:0] {S_IDLE = 3'd0, S_MULT = 3'd1, S_DIVD = 3'd2,
                              S_FIX = 3'd3, S_DONE = 3'd4} state_t;
`else
    typedef enum logic [2:0] {S_IDLE = 3'd0, S_MULT = 3'd1,
                              S_FIX = 3'd3, S_DONE = 3'd4} state_t;
`endif

    state_t      state_q, state_d;
    logic [3:0]  func_q, func_d;
    logic [63:0] acc_q, acc_d;      // multiply: {partial, multiplier}; divide: {remainder, quotient}
    logic [31:0] opb_q, opb_d;      // multiplicand or divisor magnitude
    logic [4:0]  cnt_q, cnt_d;
    logic        qneg_q, qneg_d;    // product / quotient must be negated
    logic [31:0] out_q, out_d;
    logic        div0_q, div0_d;
`ifdef BEXKAT2_INTDIV_EN
    logic        rneg_q, rneg_d;    // remainder must be negated
`endif

    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction

    logic        sgn_mul;
    logic [32:0] mul_sum;
    logic [63:0] prod;
`ifdef BEXKAT2_INTDIV_EN
    logic        sgn_div;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [31:0] quo;
    logic [31:0] rem;
`endif

    // Next-state, datapath step and result selection
    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        out_d   = out_q;
        div0_d  = 1'b0;
        sgn_mul = (func_i == F_MUL) || (func_i == F_MULX);
        mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        prod    = qneg_q ? -acc_q : acc_q;
`ifdef BEXKAT2_INTDIV_EN
        rneg_d    = rneg_q;
        sgn_div   = (func_i == F_DIV) || (func_i == F_MOD);
        div_shift = {acc_q[63:32], acc_q[31]};
        div_diff  = div_shift - {1'b0, opb_q};
        quo       = qneg_q ? -acc_q[31:0] : acc_q[31:0];
        rem       = rneg_q ? -acc_q[63:32] : acc_q[63:32];
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    func_d = func_i;
                    cnt_d  = 5'd0;
                    case (func_i)
                        F_MUL, F_MULU, F_MULX, F_MULUX: begin
                            opb_d   = mag(in1_i, sgn_mul);
                            acc_d   = {32'd0, mag(in2_i, sgn_mul)};
                            qneg_d  = sgn_mul & (in1_i[31] ^ in2_i[31]);
                            state_d = S_MULT;
                        end
`ifdef BEXKAT2_INTDIV_EN
                        F_DIV, F_MOD, F_DIVU, F_MODU: begin
                            if (in2_i == 32'd0) begin
                                out_d   = (func_i == F_DIV || func_i == F_DIVU) ? 32'hFFFF_FFFF : in1_i;
                                div0_d  = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                opb_d   = mag(in2_i, sgn_div);
                                acc_d   = {32'd0, mag(in1_i, sgn_div)};
                                qneg_d  = sgn_div & (in1_i[31] ^ in2_i[31]);
                                rneg_d  = sgn_div & in1_i[31];
                                state_d = S_DIVD;
                            end
                        end
`endif
                        F_EXT: begin
                            out_d   = {{16{in1_i[15]}}, in1_i[15:0]};
                            state_d = S_DONE;
                        end
                        F_EXTB: begin
                            out_d   = {{24{in1_i[7]}}, in1_i[7:0]};
                            state_d = S_DONE;
                        end
                        F_COM: begin
                            out_d   = ~in1_i;
                            state_d = S_DONE;
                        end
                        F_NEG: begin
                            out_d   = -in1_i;
                            state_d = S_DONE;
                        end
                        default: begin
                            out_d   = 32'd0;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_MULT: begin
                acc_d = {mul_sum, acc_q[31:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
`ifdef BEXKAT2_INTDIV_EN
            S_DIVD: begin
                if (div_shift >= {1'b0, opb_q})
                    acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                else
                    acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
`endif
            S_FIX: begin
                case (func_q)
                    F_MULX, F_MULUX: out_d = prod[63:32];
`ifdef BEXKAT2_INTDIV_EN
                    F_DIV, F_DIVU:   out_d = quo;
                    F_MOD, F_MODU:   out_d = rem;
`endif
                    default:         out_d = prod[31:0];
                endcase
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            func_q  <= 4'd0;
            acc_q   <= 64'd0;
            opb_q   <= 32'd0;
            cnt_q   <= 5'd0;
            qneg_q  <= 1'b0;
            out_q   <= 32'd0;
            div0_q  <= 1'b0;
`ifdef BEXKAT2_INTDIV_EN
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            out_q   <= out_d;
            div0_q  <= div0_d;
`ifdef BEXKAT2_INTDIV_EN
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign busy_o = (state_q == S_MULT) || (state_q == S_FIX)
`ifdef BEXKAT2_INTDIV_EN
                    || (state_q == S_DIVD)
`endif
                    ;
    assign done_o = (state_q == S_DONE);
    assign div0_o = div0_q;
    assign out_o  = out_q;
endmodule

// File: tb/tb_bexkat2_intseq.sv
// Self-checking bench for bexkat2_intseq: directed vector table, hand-written
// corner sequences and randomized operations against an arithmetic model.
// Honours BEXKAT2_INTDIV_EN the same way as the design.
module tb_bexkat2_intseq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  func = 4'd0;
    logic [31:0] in1 = 32'd0;
    logic [31:0] in2 = 32'd0;
    logic        busy, done, div0;
    logic [31:0] out;

    int nvec = 0;
    int nmis = 0;

    bexkat2_intseq dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .func_i(func),
        .in1_i(in1), .in2_i(in2), .busy_o(busy), .done_o(done),
        .out_o(out), .div0_o(div0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] o;
        int          lat;
        logic        d0;
        int          inj;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

`ifdef BEXKAT2_INTDIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    function automatic bit is_div(input logic [3:0] f);
        return (f == 4'd1) || (f == 4'd2) || (f == 4'd4) || (f == 4'd5);
    endfunction

    // Arithmetic reference: what the result should be, not how it is built
    function automatic logic [31:0] m_out(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] ua = {32'd0, a};
        logic [63:0] ub = {32'd0, b};
        logic [63:0] p;
        if (is_div(f) && !DIV_EN) return 32'd0;
        case (f)
            4'd0, 4'd3: begin p = ua * ub; return p[31:0]; end
            4'd6: begin p = 64'(sa * sb); return p[63:32]; end
            4'd7: begin p = ua * ub; return p[63:32]; end
            4'd1: begin if (b == 0) return 32'hFFFF_FFFF; p = 64'(sa / sb); return p[31:0]; end
            4'd2: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
            4'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            4'd5: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
            4'd8: begin p = 64'(longint'($signed(a[15:0]))); return p[31:0]; end
            4'd9: begin p = 64'(longint'($signed(a[7:0]))); return p[31:0]; end
            4'd10: return ~a;
            4'd11: begin p = 64'(0 - sa); return p[31:0]; end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int m_lat(input logic [3:0] f, input logic [31:0] b);
        if (f == 4'd0 || f == 4'd3 || f == 4'd6 || f == 4'd7) return 34;
        if (is_div(f) && DIV_EN && b != 0) return 34;
        return 1;
    endfunction

    function automatic logic m_d0(input logic [3:0] f, input logic [31:0] b);
        return DIV_EN && is_div(f) && (b == 0);
    endfunction

    // Launch one operation, scramble inputs while it runs, check result/timing
    task automatic run(input string nm, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eo, input int elat, input logic ed0, input int inj);
        int          n = 1;
        int          lat = -1;
        int          bz = 0;
        logic [31:0] o = 32'd0;
        logic        d0 = 1'b0;
        @(negedge clk);
        func = f; in1 = a; in2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (n <= 100) begin
            if (busy) bz++;
            if (done) begin
                o = out; d0 = div0; lat = n;
                break;
            end
            start = (n == inj);
            func = 4'($urandom); in1 = $urandom; in2 = $urandom;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({nm, " latency"}, lat, elat);
        chk({nm, " out"}, o, eo);
        chk({nm, " div0"}, d0, ed0);
        chk({nm, " busy cycles"}, bz, (elat == 34) ? 33 : 0);
        @(negedge clk);
        chk({nm, " done pulse width"}, done, 0);
        chk({nm, " out held"}, out, eo);
    endtask

    vec_t vt[$];

    initial begin
        logic [3:0]  rf;
        logic [31:0] ra, rb;
        int          nd;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset out", out, 0);
        chk("reset div0", div0, 0);
        rst_n = 1'b1;

        // Directed table
        vt.push_back('{4'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 34, 1'b0, -1});
        vt.push_back('{4'd6, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 34, 1'b0, -1});
        vt.push_back('{4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0, -1});
        vt.push_back('{4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34, 1'b0, -1});
        vt.push_back('{4'd9, 32'h0000_0080, 32'd0, 32'hFFFF_FF80, 1, 1'b0, -1});
        vt.push_back('{4'd8, 32'h1234_8001, 32'd0, 32'hFFFF_8001, 1, 1'b0, -1});
        vt.push_back('{4'd10, 32'h0F0F_0000, 32'd0, 32'hF0F0_FFFF, 1, 1'b0, -1});
        vt.push_back('{4'd11, 32'h8000_0000, 32'd0, 32'h8000_0000, 1, 1'b0, -1});
        vt.push_back('{4'd13, 32'h1234_5678, 32'd9, 32'd0, 1, 1'b0, -1});
        vt.push_back('{4'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 34, 1'b0, 10});
`ifdef BEXKAT2_INTDIV_EN
        vt.push_back('{4'd1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0, -1});
        vt.push_back('{4'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0, -1});
        vt.push_back('{4'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1'b0, -1});
        vt.push_back('{4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 1'b0, -1});
        vt.push_back('{4'd4, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 1'b1, -1});
        vt.push_back('{4'd5, 32'd100, 32'd0, 32'd100, 1, 1'b1, -1});
        vt.push_back('{4'd5, 32'hFFFF_FFFF, 32'd10, 32'd5, 34, 1'b0, -1});
`else
        vt.push_back('{4'd1, 32'd10, 32'd2, 32'd0, 1, 1'b0, -1});
        vt.push_back('{4'd4, 32'd100, 32'd0, 32'd0, 1, 1'b0, -1});
`endif
        foreach (vt[i]) run($sformatf("vec%0d f%0d", i, vt[i].f), vt[i].f, vt[i].a, vt[i].b,
                            vt[i].o, vt[i].lat, vt[i].d0, vt[i].inj);

        // Start in DONE ignored, start in the following IDLE cycle accepted
        @(negedge clk);
        func = 4'd9; in1 = 32'h0000_0080; start = 1'b1;
        @(negedge clk);
        chk("b2b first done", done, 1);
        chk("b2b first out", out, 32'hFFFF_FF80);
        func = 4'd10; in1 = 32'd0;
        @(negedge clk);
        chk("b2b done-cycle start ignored", done, 0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b second done", done, 1);
        chk("b2b second out", out, 32'hFFFF_FFFF);

        // Reset in the middle of a long operation
        @(negedge clk);
        func = DIV_EN ? 4'd4 : 4'd3; in1 = 32'd1000; in2 = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("abort busy before reset", busy, 1);
        rst_n = 1'b0; start = 1'b1; func = 4'd11; in1 = 32'd5;
        @(negedge clk);
        chk("abort busy", busy, 0);
        chk("abort out", out, 0);
        chk("abort done", done, 0);
        chk("abort div0", div0, 0);
        rst_n = 1'b1; start = 1'b0;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("abort no activity after reset", nd, 0);
        run("neg after abort", 4'd11, 32'd5, 32'd0, 32'hFFFF_FFFB, 1, 1'b0, -1);

        // Randomized operations against the model
        for (int k = 0; k < 150; k++) begin
            rf = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                2: ra = $urandom_range(0, 20);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            run($sformatf("rnd%0d f%0d", k, rf), rf, ra, rb, m_out(rf, ra, rb),
                m_lat(rf, rb), m_d0(rf, rb), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
